shm_port_arbiter: RTL

Two-requester arbiter and read-response buffer that sits directly upstream of one port of `dual_port_ram`. It multiplexes two independent valid/ready request streams onto a single RAM port, with round-robin fairness. It also owns the port's 1-cycle registered-read latency and returns read data to the originating requester through a backpressurable response channel.

---
 rtl/shm_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/shm_port_arbiter.sv
// -----------------------------------------------------------------------------
// shm_port_arbiter
//
// Purpose:
//   Shares one port of a dual-port RAM between two requesters. Each requester
//   issues valid/ready read or write requests; a round-robin arbiter grants at
//   most one request per cycle. Read data comes back from the RAM one cycle
//   after the address edge. It is captured into a single response register and
//   returned to the requester that issued the read, through a backpressurable
//   valid/ready channel.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   mX_req_valid/ready    : request handshake for requester X (0 or 1)
//   mX_req_we             : 1 = write, 0 = read
//   mX_req_addr/wdata     : word address and write data
//   mX_rsp_valid/ready    : read-response handshake for requester X
//   mX_rsp_rdata          : read data (both requesters see the same register)
//   ram_we/addr/wdata     : drive to the RAM port (all zero when nothing granted)
//   ram_rdata             : registered RAM read data, valid one cycle after addr
// -----------------------------------------------------------------------------
module shm_port_arbiter #(
    parameter int LOCAL_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        m0_req_valid,
    output logic                        m0_req_ready,
    input  logic                        m0_req_we,
    input  logic [LOCAL_ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0]       m0_req_wdata,
    output logic                        m0_rsp_valid,
    input  logic                        m0_rsp_ready,
    output logic [DATA_WIDTH-1:0]       m0_rsp_rdata,

    input  logic                        m1_req_valid,
    output logic                        m1_req_ready,
    input  logic                        m1_req_we,
    input  logic [LOCAL_ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0]       m1_req_wdata,
    output logic                        m1_rsp_valid,
    input  logic                        m1_rsp_ready,
    output logic [DATA_WIDTH-1:0]       m1_rsp_rdata,

    output logic                        ram_we,
    output logic [LOCAL_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    input  logic [DATA_WIDTH-1:0]       ram_rdata
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                  rd_pend_q,   rd_pend_d;    // read address sampled last edge
    logic                  rd_owner_q,  rd_owner_d;   // requester of the pending read
    logic                  rsp_valid_q, rsp_valid_d;  // response register occupied
    logic                  rsp_owner_q, rsp_owner_d;  // requester the response belongs to
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;   // buffered read data
    logic                  last_gnt_q,  last_gnt_d;   // round-robin pointer

    // -------------------------------------------------------------------------
    // Eligibility and grant
    // -------------------------------------------------------------------------
    logic rsp_fire;
    logic rd_ok;
    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;
    logic acc_rd;

    assign rsp_fire = rsp_valid_q && (rsp_owner_q ? m1_rsp_ready : m0_rsp_ready);

    // Only one read may be in flight or buffered at a time. A read may still be
    // accepted in the cycle the buffered response is consumed, since the new
    // data lands in the register two edges later.
    assign rd_ok = !rd_pend_q && (!rsp_valid_q || rsp_fire);

    assign elig0 = m0_req_valid && (m0_req_we || rd_ok);
    assign elig1 = m1_req_valid && (m1_req_we || rd_ok);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Grants are forced off while reset is held so nothing reaches the RAM.
        if (rst_n) begin
            if (elig0 && elig1) begin
                // Tie: the requester that did not win last time goes first.
                if (last_gnt_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;

    // Grant implies valid, so a grant is an accept.
    assign acc_rd = (gnt0 && !m0_req_we) || (gnt1 && !m1_req_we);

    // -------------------------------------------------------------------------
    // RAM drive: the granted request, or all zeros when idle
    // -------------------------------------------------------------------------
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_we    = m0_req_we;
            ram_addr  = m0_req_addr;
            ram_wdata = m0_req_wdata;
        end else if (gnt1) begin
            ram_we    = m1_req_we;
            ram_addr  = m1_req_addr;
            ram_wdata = m1_req_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        rd_pend_d   = acc_rd;
        rd_owner_d  = rd_owner_q;
        rsp_valid_d = rsp_valid_q;
        rsp_owner_d = rsp_owner_q;
        rsp_data_d  = rsp_data_q;
        last_gnt_d  = last_gnt_q;

        if (acc_rd) begin
            rd_owner_d = gnt1;
        end

        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end

        if (rsp_fire) begin
            rsp_valid_d = 1'b0;
        end

        // ram_rdata holds the word addressed at the previous edge. Capturing it
        // here (the same edge a concurrent write lands) keeps it uncorrupted.
        if (rd_pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_owner_d = rd_owner_q;
            rsp_data_d  = ram_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_data_q  <= '0;
            last_gnt_q  <= 1'b1;   // m0 wins the first tie after reset
        end else begin
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_data_q  <= rsp_data_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Response outputs
    // -------------------------------------------------------------------------
    assign m0_rsp_valid = rsp_valid_q && !rsp_owner_q;
    assign m1_rsp_valid = rsp_valid_q &&  rsp_owner_q;
    assign m0_rsp_rdata = rsp_data_q;
    assign m1_rsp_rdata = rsp_data_q;

endmodule
